// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into CHUNK-bit stages,
// each stage registering its partial sum and carry, with valid/ready on both sides.
module pipe_adder #(
    parameter int unsigned WIDTH = 8,  // >= 2
    parameter int unsigned CHUNK = 4   // must divide WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned STAGES = WIDTH / CHUNK;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Stage inputs (from the previous stage's registers, or the ports for stage 0).
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];

    // Stage register outputs.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    assign b_eff     = sub ? ~b : b;
    assign c_eff     = sub ? 1'b1 : cin;
    assign out_valid = v_q[STAGES-1];
    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance;
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [CHUNK:0]     chunk_sum;
        logic [WIDTH-1:0]   chunk_top;
        logic [WIDTH-1:0]   a_r;
        logic [WIDTH-1:0]   b_r;
        logic [WIDTH-1:0]   s_r;
        logic               c_r;
        logic               v_r;

        if (i == 0) begin : g_head
            assign a_in[i] = a;
            assign b_in[i] = b_eff;
            assign s_in[i] = '0;
            assign c_in[i] = c_eff;
            assign v_in[i] = in_valid;
        end else begin : g_body
            assign a_in[i] = a_q[i-1];
            assign b_in[i] = b_q[i-1];
            assign s_in[i] = s_q[i-1];
            assign c_in[i] = c_q[i-1];
            assign v_in[i] = v_q[i-1];
        end

        // Operands shift right one chunk per stage so each stage always adds the low chunk;
        // finished sum chunks enter from the top so the full sum lines up at the last stage.
        assign chunk_sum = {1'b0, a_in[i][CHUNK-1:0]} + {1'b0, b_in[i][CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, c_in[i]};
        assign chunk_top = WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_r <= '0;
                b_r <= '0;
                s_r <= '0;
                c_r <= 1'b0;
                v_r <= 1'b0;
            end else if (advance) begin
                a_r <= a_in[i] >> CHUNK;
                b_r <= b_in[i] >> CHUNK;
                s_r <= (s_in[i] >> CHUNK) | chunk_top;
                c_r <= chunk_sum[CHUNK];
                v_r <= v_in[i];
            end
        end

        assign a_q[i] = a_r;
        assign b_q[i] = b_r;
        assign s_q[i] = s_r;
        assign c_q[i] = c_r;
        assign v_q[i] = v_r;

        if (i == STAGES - 1) begin : g_tail
            logic carry_msb;
            logic ovf_r;

            // Carry into the MSB recovered from the MSB sum bit and its operand bits.
            assign carry_msb = chunk_sum[CHUNK-1] ^ a_in[i][CHUNK-1] ^ b_in[i][CHUNK-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (advance) begin
                    ovf_r <= carry_msb ^ chunk_sum[CHUNK];
                end
            end

            assign ovf_q = ovf_r;
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Directed and scoreboarded checks of pipe_adder at 8/4, plus latency/result sweeps
// over several WIDTH/CHUNK pairs.
module tb_pipe_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    logic        sw_rst_n;
    logic        sw_valid;
    logic [31:0] sw_a;
    logic [31:0] sw_b;
    logic        sw_cin;
    logic        sw_sub;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [63:0] m_exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Returns {ovf, cout, sum} packed as sum[w-1:0], cout at bit w, ovf at bit w+1.
    function automatic logic [63:0] model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mc, input logic ms);
        logic [63:0] mask, av, bv, full, s;
        logic        co, ov;
        mask = (64'd1 << w) - 64'd1;
        av   = 64'(ma) & mask;
        bv   = (ms ? ~64'(mb) : 64'(mb)) & mask;
        full = av + bv + (ms ? 64'd1 : 64'(mc));
        s    = full & mask;
        co   = full[w];
        ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
        return s | (64'(co) << w) | (64'(ov) << (w + 1));
    endfunction

    function automatic int sw_width(input int g);
        case (g)
            0: return 8;
            1: return 16;
            2: return 32;
            default: return 8;
        endcase
    endfunction

    function automatic int sw_chunk(input int g);
        case (g)
            0: return 8;
            1: return 4;
            2: return 8;
            default: return 1;
        endcase
    endfunction

    pipe_adder #(.WIDTH(8), .CHUNK(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Scoreboard for the main instance: every retired result is checked in order.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("main_pending", 64'(m_exp_q.size() != 0), 64'(1));
                if (m_exp_q.size() != 0) check("main_sb", 64'({ovf, cout, sum}), m_exp_q.pop_front());
            end
            if (in_valid && in_ready) m_exp_q.push_back(model(8, 32'(a), 32'(b), cin, sub));
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int W = sw_width(g);
        localparam int C = sw_chunk(g);
        localparam int S = W / C;

        logic [W-1:0] s_sum;
        logic         s_cout;
        logic         s_ovf;
        logic         s_valid;
        logic         s_ready;
        logic [63:0]  exp_q [$];
        int           acc_q [$];
        int           n_out = 0;

        pipe_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst_n     (sw_rst_n),
            .in_valid  (sw_valid),
            .in_ready  (s_ready),
            .a         (sw_a[W-1:0]),
            .b         (sw_b[W-1:0]),
            .cin       (sw_cin),
            .sub       (sw_sub),
            .out_valid (s_valid),
            .out_ready (1'b1),
            .sum       (s_sum),
            .cout      (s_cout),
            .ovf       (s_ovf)
        );

        always @(negedge clk) begin
            if (!sw_rst_n) begin
                exp_q.delete();
                acc_q.delete();
            end else begin
                if (s_valid) begin
                    n_out <= n_out + 1;
                    check($sformatf("sw%0d_pending", g), 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        check($sformatf("sw%0d_res", g), 64'({s_ovf, s_cout, s_sum}),
                              exp_q.pop_front());
                        check($sformatf("sw%0d_lat", g), 64'(cyc - acc_q.pop_front()), 64'(S - 1));
                    end
                end
                if (sw_valid && s_ready) begin
                    exp_q.push_back(model(W, sw_a, sw_b, sw_cin, sw_sub));
                    acc_q.push_back(cyc + 1);
                end
            end
        end
    end

    // Expects an empty pipeline; called 2 time units after a rising edge.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input logic ts, input logic [7:0] es,
                          input logic ec, input logic eo);
        a = ta;
        b = tb_v;
        cin = tc;
        sub = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #2 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, 64'(out_valid), 64'(0));
        @(posedge clk);
        #2;
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid), 64'(1));
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n_ov;
        int first_ov;
        int last_ov;
        int idx;
        int sw_acc;

        rst_n = 1'b0;
        sw_rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        cin = 1'b0;
        sub = 1'b0;
        sw_valid = 1'b0;
        sw_a = '0;
        sw_b = '0;
        sw_cin = 1'b0;
        sw_sub = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        sw_rst_n = 1'b1;
        @(posedge clk);
        #2;

        run_op("add_ff_00", 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_0f_cin", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        run_op("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_op("sub_cin_ign", 8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);

        // Ten back-to-back bundles must retire on ten consecutive cycles.
        n_ov = 0;
        first_ov = -1;
        last_ov = -1;
        for (int i = 0; i < 14; i++) begin
            if (i < 10) begin
                in_valid = 1'b1;
                a = 8'($urandom);
                b = 8'($urandom);
                cin = 1'($urandom);
                sub = 1'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid) begin
                n_ov++;
                if (first_ov < 0) first_ov = i;
                last_ov = i;
            end
            @(posedge clk);
            #2;
        end
        check("stream_count", 64'(n_ov), 64'(10));
        check("stream_span", 64'(last_ov - first_ov + 1), 64'(10));

        // Backpressure: out_ready low for three cycles mid-stream.
        idx = 0;
        n_ov = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            if (idx < 8) begin
                in_valid = 1'b1;
                a = 8'(8'h31 * (idx + 1));
                b = 8'(8'h57 + idx * 8'h1D);
                cin = idx[0];
                sub = idx[1];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                check("bp_in_ready", 64'(in_ready), 64'(0));
                check("bp_out_valid", 64'(out_valid), 64'(1));
                check("bp_frozen", 64'({ovf, cout, sum}), m_exp_q[0]);
            end
            if (out_valid && out_ready) n_ov++;
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #2;
        end
        out_ready = 1'b1;
        check("bp_all_sent", 64'(idx), 64'(8));
        check("bp_all_out", 64'(n_ov), 64'(8));
        check("bp_drained", 64'(m_exp_q.size()), 64'(0));

        // Reset with two operations in flight.
        in_valid = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b0;
        sub = 1'b0;
        @(posedge clk);
        #2;
        a = 8'h7F;
        b = 8'h01;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        check("rst_mid_pre_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'(0));
        check("rst_mid_sum", 64'(sum), 64'(0));
        check("rst_mid_cout", 64'(cout), 64'(0));
        check("rst_mid_ovf", 64'(ovf), 64'(0));
        check("rst_mid_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        // Parameter sweep with random operands and bubbles.
        sw_acc = 0;
        for (int i = 0; i < 30; i++) begin
            sw_valid = ($urandom_range(0, 3) != 0);
            sw_a = $urandom;
            sw_b = $urandom;
            sw_cin = 1'($urandom);
            sw_sub = 1'($urandom);
            if (sw_valid) sw_acc++;
            @(posedge clk);
            #2;
        end
        sw_valid = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        check("sw0_count", 64'(g_sweep[0].n_out), 64'(sw_acc));
        check("sw1_count", 64'(g_sweep[1].n_out), 64'(sw_acc));
        check("sw2_count", 64'(g_sweep[2].n_out), 64'(sw_acc));
        check("sw3_count", 64'(g_sweep[3].n_out), 64'(sw_acc));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
